fifo_uart_tx: RTL

Serial transmit stage that drains the team's synchronous FIFO and sends each word as an asynchronous UART frame. The frame is a start bit, WIDTH data bits LSB first, an optional parity bit, and 1 or 2 stop bits. It sits directly downstream of the FIFO, driving its read enable and consuming its registered read data. Only this block reads the FIFO.

---
 rtl/fifo_uart_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmit stage that pops words from the shared synchronous FIFO.
// Frame: start, WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             fifo_wr_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic [BW-1:0]    baud_q, baud_n;
  logic [CW-1:0]    bit_q, bit_n;
  logic             par_q, par_n;
  logic             tx_q, tx_n;
  logic             done_q, done_n;
  logic             baud_last;

  assign baud_last  = (baud_q == BAUD_LAST);
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    shift_n    = shift_q;
    baud_n     = baud_q;
    bit_n      = bit_q;
    par_n      = par_q;
    done_n     = 1'b0;
    fifo_rd_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) state_n = FETCH;
      end
      FETCH: begin
        // The FIFO drops reads that collide with a write, so wait them out.
        fifo_rd_en = !fifo_wr_en;
        if (!fifo_wr_en) state_n = LOAD;
      end
      LOAD: begin
        shift_n = fifo_rdata;
        par_n   = (^fifo_rdata) ^ ODD;
        baud_n  = '0;
        bit_n   = '0;
        state_n = START;
      end
      START: begin
        baud_n = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) state_n = DATA;
      end
      DATA: begin
        baud_n = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          shift_n = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        baud_n = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) state_n = STOP;
      end
      STOP: begin
        baud_n = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            bit_n   = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level follows the next state so tx lines up with state_q.
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule
